// File: rtl/pl_csr_trap.sv
// Machine-mode CSR file with trap entry, mret return and a one-cycle
// flush/redirect sequencer sitting beside the ID stage.
module pl_csr_trap #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_v,
  input  logic [3:0]  cause,
  input  logic        intr,
  input  logic        mret,
  input  logic        csr_en,
  input  logic [2:0]  func3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  csr_rs1,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] id_pc,
  input  logic        wpcir,
  input  logic        ext_irq,
  output logic [31:0] mstatus,
  output logic [31:0] mie,
  output logic [31:0] mip,
  output logic [31:0] mepc,
  output logic [31:0] mtvec,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;

  state_t      state;
  state_t      state_nx;

  logic        st_mie;
  logic        st_mpie;
  logic        meie;
  logic [31:0] mtvec_q;
  logic [29:0] mepc_q;
  logic [31:0] mcause;
  logic [63:0] mcycle;
  logic        irq_s1;
  logic        irq_s2;
  logic [31:0] rpc;

  logic        accept;
  logic        trap_acc;
  logic        mret_acc;
  logic        wr_ok;
  logic        csr_wr;
  logic [31:0] wval;
  logic [31:0] tvec_base;

  logic        unused;
  assign unused = ^id_pc[1:0];

  assign mstatus = {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign mie     = {20'b0, meie, 11'b0};
  assign mip     = {20'b0, irq_s2, 11'b0};
  assign mepc    = {mepc_q, 2'b00};
  assign mtvec   = mtvec_q;

  assign redirect_pc = rpc;
  assign tvec_base   = {mtvec_q[31:2], 2'b00};

  always_comb begin
    csr_rdata = 32'b0;
    case (csr_addr)
      A_MSTATUS: csr_rdata = mstatus;
      A_MIE:     csr_rdata = mie;
      A_MTVEC:   csr_rdata = mtvec_q;
      A_MEPC:    csr_rdata = mepc;
      A_MCAUSE:  csr_rdata = mcause;
      A_MIP:     csr_rdata = mip;
      A_MCYCLE:  csr_rdata = mcycle[31:0];
      A_MCYCLEH: csr_rdata = mcycle[63:32];
      default:   csr_rdata = 32'b0;
    endcase
  end

  // Priority: trap, then mret, then the CSR write; FLUSH blocks all.
  always_comb begin
    accept   = (state == RUN) && wpcir;
    trap_acc = accept && trap_v;
    mret_acc = accept && !trap_v && mret;
    wr_ok    = csr_en &&
               ((func3 == 3'b001) ||
                ((func3 == 3'b010) && (csr_rs1 != 5'd0)));
    csr_wr   = accept && !trap_v && !mret && wr_ok;
    wval     = (func3 == 3'b001) ? csr_wdata
                                 : (csr_rdata | csr_wdata);
  end

  always_comb begin
    state_nx = state;
    redirect = 1'b0;
    case (state)
      RUN: begin
        if (trap_acc || mret_acc) state_nx = FLUSH;
      end
      FLUSH: begin
        redirect = 1'b1;
        state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_s1 <= 1'b0;
      irq_s2 <= 1'b0;
    end else begin
      irq_s1 <= ext_irq;
      irq_s2 <= irq_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpc <= 32'b0;
    end else if (trap_acc) begin
      if (intr && mtvec_q[0]) rpc <= tvec_base + 32'd44;
      else                    rpc <= tvec_base;
    end else if (mret_acc) begin
      rpc <= mepc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
      meie    <= 1'b0;
      mtvec_q <= RESET_MTVEC & ~32'h2;
      mepc_q  <= 30'b0;
      mcause  <= 32'b0;
    end else if (trap_acc) begin
      mepc_q  <= id_pc[31:2];
      mcause  <= intr ? 32'h8000_000B : {28'b0, cause};
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_acc) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        A_MSTATUS: begin
          st_mie  <= wval[3];
          st_mpie <= wval[7];
        end
        A_MIE:    meie    <= wval[11];
        A_MTVEC:  mtvec_q <= wval & ~32'h2;
        A_MEPC:   mepc_q  <= wval[31:2];
        A_MCAUSE: mcause  <= wval;
        default: ;
      endcase
    end
  end

  // A written half suppresses the increment for the whole counter.
  always_ff @(posedge clk) begin
    if (rst)
      mcycle <= 64'b0;
    else if (csr_wr && csr_addr == A_MCYCLE)
      mcycle[31:0] <= wval;
    else if (csr_wr && csr_addr == A_MCYCLEH)
      mcycle[63:32] <= wval;
    else
      mcycle <= mcycle + 64'd1;
  end

endmodule

// File: tb/tb_pl_csr_trap.sv
// Scoreboard bench for pl_csr_trap: stimulus queues expectations,
// negedge monitor pops and compares them.
module tb_pl_csr_trap;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_v;
  logic [3:0]  cause;
  logic        intr;
  logic        mret;
  logic        csr_en;
  logic [2:0]  func3;
  logic [11:0] csr_addr;
  logic [4:0]  csr_rs1;
  logic [31:0] csr_wdata;
  logic [31:0] id_pc;
  logic        wpcir;
  logic        ext_irq;
  logic [31:0] mstatus, mie, mip, mepc, mtvec;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;

  pl_csr_trap #(.RESET_MTVEC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .trap_v(trap_v), .cause(cause),
    .intr(intr), .mret(mret), .csr_en(csr_en), .func3(func3),
    .csr_addr(csr_addr), .csr_rs1(csr_rs1),
    .csr_wdata(csr_wdata), .id_pc(id_pc), .wpcir(wpcir),
    .ext_irq(ext_irq), .mstatus(mstatus), .mie(mie), .mip(mip),
    .mepc(mepc), .mtvec(mtvec), .csr_rdata(csr_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef enum {
    S_MSTATUS, S_MIE, S_MIP, S_MEPC, S_MTVEC, S_RDATA, S_REDIR
  } sel_t;

  typedef struct {
    int          at;
    sel_t        sel;
    logic [31:0] exp;
    string       name;
  } obs_t;

  obs_t        oq[$];
  logic [31:0] rq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input sel_t s);
    case (s)
      S_MSTATUS: return mstatus;
      S_MIE:     return mie;
      S_MIP:     return mip;
      S_MEPC:    return mepc;
      S_MTVEC:   return mtvec;
      S_RDATA:   return csr_rdata;
      default:   return {31'b0, redirect};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] act;
    logic [31:0] e;
    if (redirect === 1'b1) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL redirect_unexpected cyc=%0d pc=%h required none",
                 cyc, redirect_pc);
      end else begin
        e = rq.pop_front();
        if (redirect_pc !== e) begin
          errors++;
          $display("FAIL redirect_pc cyc=%0d actual=%h required=%h",
                   cyc, redirect_pc, e);
        end
      end
    end
    for (int i = oq.size() - 1; i >= 0; i--) begin
      if (oq[i].at <= cyc) begin
        act = pick(oq[i].sel);
        checks++;
        if (oq[i].at < cyc || act !== oq[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%h required=%h",
                   oq[i].name, cyc, act, oq[i].exp);
        end
        oq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trap_v = 0; cause = 0; intr = 0; mret = 0;
    csr_en = 0; func3 = 0; csr_addr = 0; csr_rs1 = 0;
    csr_wdata = 0; id_pc = 0; wpcir = 1;
  endtask

  task automatic chk(input sel_t s, input logic [31:0] e,
                     input string n, input int d);
    obs_t o;
    o.at = cyc + d; o.sel = s; o.exp = e; o.name = n;
    oq.push_back(o);
  endtask

  task automatic csr(input logic [2:0] f, input logic [11:0] a,
                     input logic [4:0] r, input logic [31:0] w);
    csr_en = 1; func3 = f; csr_addr = a; csr_rs1 = r; csr_wdata = w;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; ext_irq = 0; idle();
    tick(); tick();
    rst = 0;
    chk(S_MSTATUS, 32'h0, "rst_mstatus", 0);
    chk(S_MIE, 32'h0, "rst_mie", 0);
    chk(S_MEPC, 32'h0, "rst_mepc", 0);
    chk(S_MTVEC, 32'h100, "rst_mtvec", 0);
    chk(S_REDIR, 32'h0, "rst_redirect", 0);
    tick();

    // ecall
    idle(); csr(3'b001, 12'h300, 5'd1, 32'h8);
    chk(S_MSTATUS, 32'h08, "set_mie", 1);
    tick();
    idle(); trap_v = 1; cause = 1; id_pc = 32'h40;
    rq.push_back(32'h100);
    chk(S_REDIR, 32'h1, "ecall_redir", 1);
    chk(S_MSTATUS, 32'h80, "ecall_mstatus", 1);
    chk(S_MEPC, 32'h40, "ecall_mepc", 1);
    tick();
    idle(); csr_addr = 12'h342;
    chk(S_RDATA, 32'h1, "ecall_mcause", 0);
    tick();
    idle();
    chk(S_REDIR, 32'h0, "ecall_back_run", 0);

    // mret
    csr(3'b001, 12'h341, 5'd1, 32'h47);
    chk(S_MEPC, 32'h44, "mepc_align", 1);
    tick();
    idle(); mret = 1;
    rq.push_back(32'h44);
    chk(S_MSTATUS, 32'h88, "mret_mstatus", 1);
    tick();
    idle(); tick();

    // vectored interrupt, trap_v held through FLUSH
    idle(); csr(3'b001, 12'h305, 5'd1, 32'h203);
    chk(S_MTVEC, 32'h201, "mtvec_bit1", 1);
    tick();
    idle(); trap_v = 1; intr = 1; id_pc = 32'h80;
    rq.push_back(32'h22C);
    chk(S_MSTATUS, 32'h80, "irq_mstatus", 1);
    tick();
    idle(); trap_v = 1; id_pc = 32'h99C; csr_addr = 12'h342;
    chk(S_RDATA, 32'h8000_000B, "irq_mcause", 0);
    tick();
    idle();
    chk(S_REDIR, 32'h0, "flush_no_retrap", 0);
    chk(S_MEPC, 32'h80, "flush_mepc_hold", 0);
    csr(3'b001, 12'h305, 5'd1, 32'h100);
    tick();

    // CSR ops
    idle(); csr(3'b001, 12'h300, 5'd1, 32'hFFFF_FFFF);
    chk(S_MSTATUS, 32'h88, "csrrw_mstatus", 1);
    tick();
    idle(); csr(3'b011, 12'h300, 5'd1, 32'h88);
    chk(S_MSTATUS, 32'h88, "bad_func3_nowr", 1);
    tick();
    idle(); csr(3'b001, 12'h304, 5'd1, 32'h0);
    tick();
    idle(); csr(3'b010, 12'h304, 5'd0, 32'hFFFF_FFFF);
    chk(S_RDATA, 32'h0, "csrrs_rs0_rdata", 0);
    chk(S_MIE, 32'h0, "csrrs_rs0_nowr", 1);
    tick();
    idle(); csr(3'b010, 12'h304, 5'd3, 32'hFFFF_FFFF);
    chk(S_MIE, 32'h800, "csrrs_mie", 1);
    tick();
    idle(); csr_addr = 12'h123;
    chk(S_RDATA, 32'h0, "unmapped_rd", 0);
    tick();

    // interrupt synchroniser and read-only mip
    idle(); ext_irq = 1;
    chk(S_MIP, 32'h0, "mip_lat1", 1);
    chk(S_MIP, 32'h800, "mip_lat2", 2);
    tick(); tick();
    idle(); csr(3'b001, 12'h344, 5'd1, 32'h0);
    chk(S_RDATA, 32'h800, "mip_rdata", 0);
    chk(S_MIP, 32'h800, "mip_ro", 1);
    tick();

    // 64-bit counter wrap and half writes
    idle(); csr(3'b001, 12'hB80, 5'd1, 32'hFFFF_FFFF);
    tick();
    idle(); csr(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF);
    tick();
    idle(); csr_addr = 12'hB80;
    chk(S_RDATA, 32'hFFFF_FFFF, "mcycleh_max", 0);
    tick();
    idle(); csr_addr = 12'hB00;
    chk(S_RDATA, 32'h0, "mcycle_wrap_lo", 0);
    tick();
    idle(); csr_addr = 12'hB80;
    chk(S_RDATA, 32'h0, "mcycle_wrap_hi", 0);
    tick();
    idle(); csr(3'b001, 12'hB00, 5'd1, 32'h5);
    tick();
    idle(); csr_addr = 12'hB00;
    chk(S_RDATA, 32'h5, "mcycle_wr", 0);
    tick();
    idle(); csr_addr = 12'hB00;
    chk(S_RDATA, 32'h6, "mcycle_inc", 0);
    tick();

    // stall
    idle(); wpcir = 0; trap_v = 1; cause = 2; id_pc = 32'h300;
    chk(S_REDIR, 32'h0, "stall_redir", 1);
    chk(S_MEPC, 32'h80, "stall_mepc", 1);
    chk(S_MSTATUS, 32'h88, "stall_mstatus", 1);
    tick();

    // reset during FLUSH
    idle(); csr(3'b001, 12'h305, 5'd1, 32'h180);
    tick();
    idle(); trap_v = 1; cause = 2; id_pc = 32'h500;
    rq.push_back(32'h180);
    chk(S_REDIR, 32'h1, "pre_rst_redir", 1);
    tick();
    idle(); rst = 1;
    tick();
    rst = 0;
    chk(S_REDIR, 32'h0, "rst_abort_redir", 0);
    chk(S_MTVEC, 32'h100, "rst_mtvec2", 0);
    chk(S_MSTATUS, 32'h0, "rst_mstatus2", 0);
    chk(S_MEPC, 32'h0, "rst_mepc2", 0);
    chk(S_MIP, 32'h0, "rst_sync", 0);
    tick(); tick(); tick();

    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL redirect_missing actual=%0d pending required=0",
               rq.size());
    end
    checks++;
    if (oq.size() != 0) begin
      errors++;
      $display("FAIL obs_pending actual=%0d required=0", oq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pl_csr_trap.md
PL_CSR_TRAP -- requirements
Module: pl_csr_trap

Interface
REQ-001 SHALL take parameter: RESET_MTVEC, 32'h0000_0100, mtvec value loaded at reset.
REQ-002 SHALL have ports, in order:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- trap_v  in  1  ID trap request.
- cause  in  4  ID exception code: 1 = ecall, 2 = illegal.
- intr  in  1  ID trap is the machine external interrupt.
- mret  in  1  ID holds mret.
- csr_en  in  1  ID holds a SYSTEM-opcode instruction.
- func3  in  3  ID func3.
- csr_addr  in  12  ID instruction bits [31:20].
- csr_rs1  in  5  rs1 index.
- csr_wdata  in  32  forwarded rs1 value.
- id_pc  in  32  PC of the ID instruction.
- wpcir  in  1  ID not stalled.
- ext_irq  in  1  asynchronous level interrupt request.
- mstatus, mie, mip, mepc, mtvec  out  32 each  architectural CSR values.
- csr_rdata  out  32  old value of the addressed CSR; combinational.
- redirect  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  32  redirect target; valid while redirect = 1.

Function
REQ-003 SHALL implement a two-state FSM.
- States: RUN and FLUSH.
- RUN -> FLUSH on an accepted trap or accepted mret.
- FLUSH -> RUN unconditionally after one cycle.
REQ-004 In FLUSH, trap_v, mret and CSR writes SHALL be ignored.
REQ-005 The accept condition SHALL be: state RUN & wpcir.
REQ-006 On the same edge, priority SHALL be trap_v > mret > CSR write.
REQ-007 Trap accept SHALL update state on the accept edge:
- mepc <= {id_pc[31:2], 2'b00}.
- mcause <= intr ? 32'h8000_000B : {28'b0, cause}.
- mstatus[7] (MPIE) <= mstatus[3]; mstatus[3] (MIE) <= 0.
REQ-008 Trap accept SHALL produce redirect = 1 in the following (FLUSH) cycle. redirect_pc in that cycle:
- intr & mtvec[0] = 1: {mtvec[31:2], 2'b00} + 44.
- all other traps: {mtvec[31:2], 2'b00}.
REQ-009 mret accept SHALL:
- set MIE <= MPIE and MPIE <= 1;
- assert redirect the next cycle with redirect_pc = mepc.
REQ-010 redirect SHALL be 0 whenever the state is RUN.
REQ-011 The CSR map SHALL be:
- mstatus 0x300: only bits 3 and 7 writable; all other bits read 0.
- mie 0x304: only bit 11 writable.
- mtvec 0x305: bit 1 reads 0.
- mepc 0x341: bits [1:0] read 0.
- mcause 0x342: fully writable.
- mip 0x344: read-only; bit 11 = synchronised ext_irq; writes ignored.
- mcycle 0xB00 / mcycleh 0xB80: low / high halves of a 64-bit cycle counter.
- Any unmapped address reads 0, and writes to it are ignored.
REQ-012 CSR write types:
- func3 = 001 (csrrw): new value = csr_wdata.
- func3 = 010 (csrrs): new value = old | csr_wdata; no write when csr_rs1 = 0.
- Any other func3: no write.
REQ-013 csr_rdata SHALL be the pre-write value of csr_addr in every cycle, independent of csr_en.
REQ-014 ext_irq SHALL pass through a 2-flop synchroniser.
- mip[11] = second flop.
- Latency from ext_irq to mip[11] is 2 cycles.
REQ-015 The 64-bit mcycle SHALL increment by 1 every cycle and wrap 2^64-1 -> 0.
REQ-016 In a cycle where mcycle or mcycleh is written, the written half SHALL take the written value. The other half SHALL hold its value; no increment or carry is applied in that cycle.
REQ-017 A CSR write SHALL take effect on the accept edge and be visible on outputs the next cycle.

Reset
REQ-018 When rst = 1 at a rising edge, all of the following SHALL be cleared, with priority over every other event in that cycle:
- state <= RUN;
- mstatus, mie, mepc, mcause, mcycle <= 0;
- mtvec <= RESET_MTVEC;
- synchroniser flops <= 0;
- redirect <= 0.
REQ-019 A reset asserted during FLUSH SHALL abort the redirect: redirect = 0 in the cycle after reset.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ecall: trap_v = 1, cause = 1, id_pc = 0x40, mtvec = 0x100, MIE = 1 -> next cycle redirect = 1, redirect_pc = 0x100, mepc = 0x40, mcause = 1, mstatus = 0x80.
- vectored interrupt: mtvec = 0x201, intr = 1, trap_v = 1 -> redirect_pc = 0x22C, mcause = 0x8000000B; a trap_v held during FLUSH causes no second redirect.
- mret: mepc = 0x44, mstatus = 0x80, mret = 1 -> redirect_pc = 0x44, mstatus = 0x88.
- CSR ops:
  - csrrw 0x300 with wdata = 0xFFFFFFFF -> mstatus = 0x88.
  - csrrs 0x304 with csr_rs1 = 0 -> no change; csr_rdata = old mie.
  - write 0x344 -> mip unchanged.
- counter: mcycle = 0xFFFFFFFF_FFFFFFFF -> reads 0 next cycle; csrrw 0xB00 = 5 -> low half reads 5, then 6.
- stall / reset: wpcir = 0 with trap_v = 1 -> no state change. rst asserted in FLUSH -> redirect = 0, mtvec = 0x100.
